mantissa_normalizer: RTL and testbench

//  Sequential left-normalizer for 28-bit mantissas; sits directly upstream of the 28-bit

---
 rtl/mantissa_normalizer_if.sv | 27 ++
 rtl/mantissa_normalizer.sv | 138 +++++++++++++
 tb/tb_mantissa_normalizer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mantissa_normalizer_if.sv
// Handshake and data bundle for the mantissa normalizer.
// master = upstream/downstream environment, slave = the normalizer itself.
interface mantissa_normalizer_if #(
  parameter int K  = 28,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          out_denorm;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_denorm
  );
endinterface

// File: rtl/mantissa_normalizer.sv
// Sequential left-normalizer: shifts a K-bit mantissa until its MSB is set, decrementing the exponent.
// Optional NORM_FAST_SHIFT_EN enables 4-bit steps when the top nibble is clear and exp >= 4.
module mantissa_normalizer #(
  parameter int K  = 28,
  parameter int EW = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  mantissa_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [EW-1:0] EXP_FOUR = EW'(4);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [K-1:0]  r_mant;
  logic [EW-1:0] r_exp;
  logic          r_zero;
  logic          r_denorm;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_in_is_zero;
  logic          w_in_done;
  logic          w_fast;
  logic [K-1:0]  w_step_mant;
  logic [EW-1:0] w_step_exp;
  logic          w_step_done;

  // Ready is withheld while reset is asserted, even though the state is already IDLE.
  assign w_in_ready   = (r_state == S_IDLE) && Reset;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_in_is_zero = (bus.in_mant == '0);
  assign w_in_done    = w_in_is_zero || bus.in_mant[K-1] || (bus.in_exp == '0);

  // One normalization step. SHIFT is only entered with a non-zero exponent and
  // left as soon as it hits zero, so the subtraction cannot wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
`ifdef NORM_FAST_SHIFT_EN
    w_fast = (r_mant[K-1:K-4] == '0) && (r_exp >= EXP_FOUR);
`else
    w_fast = 1'b0;
`endif
    if (w_fast) begin
      w_step_mant = r_mant << 4;
      w_step_exp  = r_exp - EXP_FOUR;
    end else begin
      w_step_mant = r_mant << 1;
      w_step_exp  = r_exp - EXP_ONE;
    end
    w_step_done = w_step_mant[K-1] || (w_step_exp == '0);
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_in_done ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_step_done) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers. These feed the downstream register bank directly, so
  // they are cleared by reset rather than left holding stale data.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous here; these are a handful of flops, not a memory array.
    if (!Reset) begin
      r_mant   <= '0;
      r_exp    <= '0;
      r_zero   <= 1'b0;
      r_denorm <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_in_is_zero) begin
              r_mant   <= '0;
              r_exp    <= '0;
              r_zero   <= 1'b1;
              r_denorm <= 1'b0;
            end else begin
              r_mant   <= bus.in_mant;
              r_exp    <= bus.in_exp;
              r_zero   <= 1'b0;
              r_denorm <= !bus.in_mant[K-1] && (bus.in_exp == '0);
            end
          end
        end
        S_SHIFT: begin
          r_mant <= w_step_mant;
          r_exp  <= w_step_exp;
          if ((w_step_exp == '0) && !w_step_mant[K-1]) r_denorm <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_zero   <= 1'b0;
            r_denorm <= 1'b0;
          end
        end
        default: begin
          r_zero   <= 1'b0;
          r_denorm <= 1'b0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    bus.in_ready   = w_in_ready;
    bus.out_valid  = (r_state == S_DONE);
    bus.out_mant   = r_mant;
    bus.out_exp    = r_exp;
    bus.out_zero   = r_zero;
    bus.out_denorm = r_denorm;
  end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed, table-driven bench for mantissa_normalizer plus hand-written hold and reset sequences.
// Expected latencies follow NORM_FAST_SHIFT_EN when it is defined for the build.
module tb_mantissa_normalizer;

  localparam int K  = 28;
  localparam int EW = 8;

  typedef struct {
    logic [K-1:0]  mant;
    logic [EW-1:0] exp;
    logic [K-1:0]  e_mant;
    logic [EW-1:0] e_exp;
    logic          e_zero;
    logic          e_denorm;
    int            lat_slow;
    int            lat_fast;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[11];

  mantissa_normalizer_if #(.K(K), .EW(EW)) bus ();

  mantissa_normalizer #(.K(K), .EW(EW)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef NORM_FAST_SHIFT_EN
    return v.lat_fast;
`else
    return v.lat_slow;
`endif
  endfunction

  // Present one input, wait for out_valid, check result and latency; leaves the block in DONE.
  task automatic accept_wait(input vec_t v, input string tag);
    int cyc;
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_mant  = v.mant;
    bus.in_exp   = v.exp;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_mant  = '0;
    bus.in_exp   = '0;
    cyc = 1;
    while (!bus.out_valid && cyc < 64) begin
      tick();
      cyc++;
    end
    check({tag, " latency"},    32'(cyc),            32'(exp_lat(v)));
    check({tag, " out_mant"},   32'(bus.out_mant),   32'(v.e_mant));
    check({tag, " out_exp"},    32'(bus.out_exp),    32'(v.e_exp));
    check({tag, " out_zero"},   32'(bus.out_zero),   32'(v.e_zero));
    check({tag, " out_denorm"}, 32'(bus.out_denorm), 32'(v.e_denorm));
    check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid cleared"},  32'(bus.out_valid),  32'd0);
    check({tag, " out_zero cleared"},   32'(bus.out_zero),   32'd0);
    check({tag, " out_denorm cleared"}, 32'(bus.out_denorm), 32'd0);
    check({tag, " in_ready idle"},      32'(bus.in_ready),   32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           mant          exp     e_mant        e_exp  z     d     slow fast
    vecs[0]  = '{28'h8000000, 8'h7F, 28'h8000000, 8'h7F, 1'b0, 1'b0, 1,   1};
    vecs[1]  = '{28'h0000001, 8'h80, 28'h8000000, 8'h65, 1'b0, 1'b0, 28,  10};
    vecs[2]  = '{28'h0000000, 8'h55, 28'h0000000, 8'h00, 1'b1, 1'b0, 1,   1};
    vecs[3]  = '{28'h0001000, 8'h03, 28'h0008000, 8'h00, 1'b0, 1'b1, 4,   4};
    vecs[4]  = '{28'h0400000, 8'h00, 28'h0400000, 8'h00, 1'b0, 1'b1, 1,   1};
    vecs[5]  = '{28'h8000001, 8'h00, 28'h8000001, 8'h00, 1'b0, 1'b0, 1,   1};
    vecs[6]  = '{28'h4000000, 8'h10, 28'h8000000, 8'h0F, 1'b0, 1'b0, 2,   2};
    vecs[7]  = '{28'h0000003, 8'h04, 28'h0000030, 8'h00, 1'b0, 1'b1, 5,   2};
    vecs[8]  = '{28'h00ABCDE, 8'h20, 28'hABCDE00, 8'h18, 1'b0, 1'b0, 9,   3};
    vecs[9]  = '{28'h0000100, 8'h0A, 28'h0040000, 8'h00, 1'b0, 1'b1, 11,  5};
    vecs[10] = '{28'h0000001, 8'h1B, 28'h8000000, 8'h00, 1'b0, 1'b0, 28,  10};

    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state: outputs cleared, ready held low while reset is asserted.
    tick();
    tick();
    check("reset out_valid",  32'(bus.out_valid),  32'd0);
    check("reset out_mant",   32'(bus.out_mant),   32'd0);
    check("reset out_exp",    32'(bus.out_exp),    32'd0);
    check("reset out_zero",   32'(bus.out_zero),   32'd0);
    check("reset out_denorm", 32'(bus.out_denorm), 32'd0);
    check("reset in_ready",   32'(bus.in_ready),   32'd0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      accept_wait(vecs[i], $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // Hold a result for 5 cycles with in_valid asserted; it must be ignored.
    accept_wait(vecs[1], "hold");
    bus.in_valid = 1'b1;
    bus.in_mant  = 28'h0000123;
    bus.in_exp   = 8'h44;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d out_mant", c),  32'(bus.out_mant),  32'h8000000);
      check($sformatf("hold%0d out_exp", c),   32'(bus.out_exp),   32'h65);
      check($sformatf("hold%0d in_ready", c),  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_mant  = '0;
    bus.in_exp   = '0;
    release_result("hold");
    accept_wait(vecs[6], "back2back");
    release_result("back2back");

    // Reset asserted for one edge in the middle of a long shift.
    bus.in_mant  = 28'h0000001;
    bus.in_exp   = 8'h80;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("midshift out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst out_valid",  32'(bus.out_valid),  32'd0);
    check("midrst out_mant",   32'(bus.out_mant),   32'd0);
    check("midrst out_exp",    32'(bus.out_exp),    32'd0);
    check("midrst out_zero",   32'(bus.out_zero),   32'd0);
    check("midrst out_denorm", 32'(bus.out_denorm), 32'd0);
    check("midrst in_ready",   32'(bus.in_ready),   32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst in_ready release", 32'(bus.in_ready), 32'd1);
    accept_wait(vecs[3], "after_rst");
    release_result("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
